// File: rtl/div_pkg.sv
// div_pkg
// Shared types and constants for the divider request controller.
//   XLEN     : default operand/result width
//   INT_MIN  : most negative XLEN-bit signed value
//   funct3_e : RV32M divide/remainder encodings
//   state_e  : controller states
package div_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {
    F3_DIV  = 3'b100,
    F3_DIVU = 3'b101,
    F3_REM  = 3'b110,
    F3_REMU = 3'b111
  } funct3_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_RESP,
    S_DRAIN
  } state_e;

  // DIV and REM interpret their operands as two's complement
  function automatic logic f3_is_signed(input logic [2:0] f3);
    return (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/div_req_ctrl_special_case.sv
// div_special_case
// Combinational detection of the cases answered without the divider,
// plus the already-selected quotient/remainder for those cases.
//   i_funct3    : request funct3
//   i_rs1/i_rs2 : dividend / divisor
//   o_is_signed : op is DIV or REM
//   o_sel_rem   : op returns the remainder
//   o_illegal   : funct3 is not a divide/remainder encoding
//   o_fast      : illegal, divide-by-zero or signed overflow
//   o_data      : selected result for the fast cases (0 when illegal)
module div_special_case #(
  parameter int XLEN = div_pkg::XLEN
) (
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  output logic            o_is_signed,
  output logic            o_sel_rem,
  output logic            o_illegal,
  output logic            o_fast,
  output logic [XLEN-1:0] o_data
);
  import div_pkg::*;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic            w_div_zero;
  logic            w_overflow;
  logic [XLEN-1:0] w_q;
  logic [XLEN-1:0] w_r;

  // Priority matches the architectural results: illegal first, then
  // divide-by-zero (q = all ones, r = dividend), then MIN/-1 overflow
  // (q = MIN, r = 0).
  always_comb begin
    o_illegal   = ~i_funct3[2];
    o_is_signed = f3_is_signed(i_funct3);
    o_sel_rem   = i_funct3[1];
    w_div_zero  = (i_rs2 == '0);
    w_overflow  = o_is_signed && (i_rs1 == MIN_NEG) && (i_rs2 == '1);
    o_fast      = o_illegal | w_div_zero | w_overflow;
    w_q         = '0;
    w_r         = '0;
    if (o_illegal) begin
      w_q = '0;
      w_r = '0;
    end else if (w_div_zero) begin
      w_q = '1;
      w_r = i_rs1;
    end else if (w_overflow) begin
      w_q = MIN_NEG;
      w_r = '0;
    end
    o_data = o_sel_rem ? w_r : w_q;
  end

endmodule

// File: rtl/div_req_ctrl.sv
// div_req_ctrl
// Initiator side of the divider handshake. Accepts DIV/DIVU/REM/REMU from
// EX, answers special cases and repeated operands locally, otherwise
// launches the divider and returns the selected quotient or remainder.
//   clk_i, reset_i              : clock, async active-high reset
//   req_valid_i/req_ready_o     : request handshake (funct3, rs1, rs2, tag)
//   flush_i                     : kill the in-flight op
//   resp_valid_o/resp_ready_i   : response handshake (data, tag, err)
//   div_start_o, div_is_signed_o, div_dividend_o, div_divisor_o : to divider
//   div_quotient_i, div_remainder_i, div_done_i                 : from divider
module div_req_ctrl #(
  parameter int XLEN    = div_pkg::XLEN,
  parameter int TAG_W   = 5,
  parameter int TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [2:0]       req_funct3_i,
  input  logic [XLEN-1:0]  req_rs1_i,
  input  logic [XLEN-1:0]  req_rs2_i,
  input  logic [TAG_W-1:0] req_tag_i,
  input  logic             flush_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [XLEN-1:0]  resp_data_o,
  output logic [TAG_W-1:0] resp_tag_o,
  output logic             resp_err_o,
  output logic             div_start_o,
  output logic             div_is_signed_o,
  output logic [XLEN-1:0]  div_dividend_o,
  output logic [XLEN-1:0]  div_divisor_o,
  input  logic [XLEN-1:0]  div_quotient_i,
  input  logic [XLEN-1:0]  div_remainder_i,
  input  logic             div_done_i
);
  import div_pkg::*;

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  state_e           r_state;
  logic [CW-1:0]    r_count;
  logic [TAG_W-1:0] r_tag;
  logic             r_sel_rem;
  logic             r_cache_valid;
  logic [XLEN-1:0]  r_cache_q;
  logic [XLEN-1:0]  r_cache_r;

  logic             w_sc_signed;
  logic             w_sc_sel_rem;
  logic             w_sc_illegal;
  logic             w_sc_fast;
  logic [XLEN-1:0]  w_sc_data;
  logic             w_accept;
  logic             w_hit;

  div_special_case #(.XLEN(XLEN)) u_special (
    .i_funct3    (req_funct3_i),
    .i_rs1       (req_rs1_i),
    .i_rs2       (req_rs2_i),
    .o_is_signed (w_sc_signed),
    .o_sel_rem   (w_sc_sel_rem),
    .o_illegal   (w_sc_illegal),
    .o_fast      (w_sc_fast),
    .o_data      (w_sc_data)
  );

  // The divider operand registers only change on a launch, so together with
  // r_cache_valid they double as the cache key for the last divider result.
  assign w_accept = (r_state == S_IDLE) && req_valid_i && !flush_i;
  assign w_hit    = r_cache_valid && (req_rs1_i == div_dividend_o) &&
                    (req_rs2_i == div_divisor_o) &&
                    (w_sc_signed == div_is_signed_o);

  // Single FSM with registered outputs. The divider cannot be aborted, so a
  // flush during LAUNCH/WAIT parks in DRAIN until done or timeout.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state         <= S_IDLE;
      r_count         <= '0;
      r_tag           <= '0;
      r_sel_rem       <= 1'b0;
      r_cache_valid   <= 1'b0;
      r_cache_q       <= '0;
      r_cache_r       <= '0;
      req_ready_o     <= 1'b1;
      resp_valid_o    <= 1'b0;
      resp_data_o     <= '0;
      resp_tag_o      <= '0;
      resp_err_o      <= 1'b0;
      div_start_o     <= 1'b0;
      div_is_signed_o <= 1'b0;
      div_dividend_o  <= '0;
      div_divisor_o   <= '0;
    end else begin
      div_start_o <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            req_ready_o <= 1'b0;
            r_tag       <= req_tag_i;
            r_sel_rem   <= w_sc_sel_rem;
            if (w_sc_fast) begin
              r_state      <= S_RESP;
              resp_valid_o <= 1'b1;
              resp_data_o  <= w_sc_data;
              resp_err_o   <= w_sc_illegal;
              resp_tag_o   <= req_tag_i;
            end else if (w_hit) begin
              r_state      <= S_RESP;
              resp_valid_o <= 1'b1;
              resp_data_o  <= w_sc_sel_rem ? r_cache_r : r_cache_q;
              resp_err_o   <= 1'b0;
              resp_tag_o   <= req_tag_i;
            end else begin
              r_state         <= S_LAUNCH;
              r_cache_valid   <= 1'b0;
              div_start_o     <= 1'b1;
              div_dividend_o  <= req_rs1_i;
              div_divisor_o   <= req_rs2_i;
              div_is_signed_o <= w_sc_signed;
            end
          end
        end
        S_LAUNCH: begin
          r_count <= '0;
          r_state <= flush_i ? S_DRAIN : S_WAIT;
        end
        S_WAIT: begin
          r_count <= r_count + CW'(1);
          if (flush_i) begin
            // A done or timeout in the flush cycle already ends the op
            if (div_done_i || (r_count == TO_LAST)) begin
              r_state     <= S_IDLE;
              req_ready_o <= 1'b1;
            end else begin
              r_state <= S_DRAIN;
            end
          end else if (div_done_i) begin
            r_state       <= S_RESP;
            r_cache_valid <= 1'b1;
            r_cache_q     <= div_quotient_i;
            r_cache_r     <= div_remainder_i;
            resp_valid_o  <= 1'b1;
            resp_data_o   <= r_sel_rem ? div_remainder_i : div_quotient_i;
            resp_err_o    <= 1'b0;
            resp_tag_o    <= r_tag;
          end else if (r_count == TO_LAST) begin
            r_state      <= S_RESP;
            resp_valid_o <= 1'b1;
            resp_data_o  <= '0;
            resp_err_o   <= 1'b1;
            resp_tag_o   <= r_tag;
          end
        end
        S_RESP: begin
          // Flush drops the response; either way the next cycle is IDLE
          if (flush_i || resp_ready_i) begin
            r_state      <= S_IDLE;
            req_ready_o  <= 1'b1;
            resp_valid_o <= 1'b0;
            resp_data_o  <= '0;
            resp_tag_o   <= '0;
            resp_err_o   <= 1'b0;
          end
        end
        S_DRAIN: begin
          r_count <= r_count + CW'(1);
          if (div_done_i || (r_count >= TO_LAST)) begin
            r_state     <= S_IDLE;
            req_ready_o <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          req_ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_req_ctrl.sv
// tb_div_req_ctrl
// Self-checking bench for div_req_ctrl: a behavioural divider answers
// launches, and an arithmetic reference model predicts every response,
// its latency and whether the divider should have been started.
module tb_div_req_ctrl;
  import div_pkg::*;

  localparam int TIMEOUT = 64;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [2:0]  req_funct3_i;
  logic [31:0] req_rs1_i;
  logic [31:0] req_rs2_i;
  logic [4:0]  req_tag_i;
  logic        flush_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] resp_data_o;
  logic [4:0]  resp_tag_o;
  logic        resp_err_o;
  logic        div_start_o;
  logic        div_is_signed_o;
  logic [31:0] div_dividend_o;
  logic [31:0] div_divisor_o;
  logic [31:0] divQ;
  logic [31:0] divR;
  logic        divDone;

  div_req_ctrl #(.XLEN(32), .TAG_W(5), .TIMEOUT(TIMEOUT)) dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_funct3_i    (req_funct3_i),
    .req_rs1_i       (req_rs1_i),
    .req_rs2_i       (req_rs2_i),
    .req_tag_i       (req_tag_i),
    .flush_i         (flush_i),
    .resp_valid_o    (resp_valid_o),
    .resp_ready_i    (resp_ready_i),
    .resp_data_o     (resp_data_o),
    .resp_tag_o      (resp_tag_o),
    .resp_err_o      (resp_err_o),
    .div_start_o     (div_start_o),
    .div_is_signed_o (div_is_signed_o),
    .div_dividend_o  (div_dividend_o),
    .div_divisor_o   (div_divisor_o),
    .div_quotient_i  (divQ),
    .div_remainder_i (divR),
    .div_done_i      (divDone)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int startCount = 0;

  // Behavioural divider state
  logic        divPending;
  int          divCnt;
  int          divDelay;
  logic        divWithhold;
  logic [31:0] divA;
  logic [31:0] divB;
  logic        divSgn;

  // Reference-model cache: operands of the last completed divider run
  logic        mCacheValid;
  logic [31:0] mA;
  logic [31:0] mB;
  logic        mSgn;

  // RISC-V division semantics with plain arithmetic; returns {q, r}
  function automatic logic [63:0] divCompute(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a;
      r = 32'd0;
    end else if (sgn) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r};
  endfunction

  // Expected {err, data} of one request
  function automatic logic [32:0] refResult(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] qr;
    if (!f3[2]) return {1'b1, 32'd0};
    qr = divCompute(!f3[0], a, b);
    return {1'b0, f3[1] ? qr[31:0] : qr[63:32]};
  endfunction

  function automatic logic isFast(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return !f3[2] || (b == 32'd0) || (!f3[0] && a == INT_MIN && b == 32'hFFFF_FFFF);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Divider: samples start away from the clock edge, answers after divDelay
  initial begin
    divDone    = 1'b0;
    divQ       = '0;
    divR       = '0;
    divPending = 1'b0;
    divCnt     = 0;
    forever begin
      @(negedge clk_i);
      divDone = 1'b0;
      if (divPending) begin
        if (divCnt == 0) begin
          {divQ, divR} = divCompute(divSgn, divA, divB);
          divDone      = 1'b1;
          divPending   = 1'b0;
        end else begin
          divCnt--;
        end
      end
      if (div_start_o) begin
        startCount++;
        if (!divWithhold) begin
          divPending = 1'b1;
          divCnt     = divDelay;
          divA       = div_dividend_o;
          divB       = div_divisor_o;
          divSgn     = div_is_signed_o;
        end
      end
    end
  end

  // One full request/response transaction checked against the model
  task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] tag, input int hold);
    logic [32:0] exp;
    logic        fast;
    logic        hit;
    int          expLat;
    int          startsBefore;
    int          lat;
    lat = 0;
    while (!req_ready_o && lat < 200) begin
      @(negedge clk_i);
      lat++;
    end
    checkOutput("reqReady", {31'd0, req_ready_o}, 32'd1);
    fast   = isFast(f3, a, b);
    hit    = !fast && mCacheValid && a == mA && b == mB && (!f3[0]) == mSgn;
    exp    = refResult(f3, a, b);
    expLat = (fast || hit) ? 1 : (divWithhold ? 2 + TIMEOUT : 3 + divDelay);
    if (!fast && !hit && divWithhold) exp = {1'b1, 32'd0};
    startsBefore = startCount;
    resp_ready_i = (hold == 0);
    req_valid_i  = 1'b1;
    req_funct3_i = f3;
    req_rs1_i    = a;
    req_rs2_i    = b;
    req_tag_i    = tag;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    req_rs1_i   = $urandom;
    req_rs2_i   = $urandom;
    req_tag_i   = 5'($urandom);
    lat = 1;
    while (!resp_valid_o && lat < 200) begin
      @(negedge clk_i);
      lat++;
    end
    checkOutput("respValid", {31'd0, resp_valid_o}, 32'd1);
    checkOutput("latency", lat, expLat);
    checkOutput("data", resp_data_o, exp[31:0]);
    checkOutput("err", {31'd0, resp_err_o}, {31'd0, exp[32]});
    checkOutput("tag", {27'd0, resp_tag_o}, {27'd0, tag});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_i);
      checkOutput("holdValid", {31'd0, resp_valid_o}, 32'd1);
      checkOutput("holdData", resp_data_o, exp[31:0]);
      checkOutput("holdTag", {27'd0, resp_tag_o}, {27'd0, tag});
    end
    resp_ready_i = 1'b1;
    @(negedge clk_i);
    checkOutput("respDrop", {31'd0, resp_valid_o}, 32'd0);
    checkOutput("starts", startCount - startsBefore, (fast || hit) ? 0 : 1);
    if (!fast && !hit) begin
      mCacheValid = !divWithhold;
      mA          = a;
      mB          = b;
      mSgn        = !f3[0];
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lastA;
    logic [31:0] lastB;
    int          sel;
    logic        drainBad;
    int          startsBefore;

    reset_i      = 1'b1;
    req_valid_i  = 1'b0;
    req_funct3_i = '0;
    req_rs1_i    = '0;
    req_rs2_i    = '0;
    req_tag_i    = '0;
    flush_i      = 1'b0;
    resp_ready_i = 1'b1;
    divDelay     = 0;
    divWithhold  = 1'b0;
    mCacheValid  = 1'b0;
    mA = '0; mB = '0; mSgn = 1'b0;

    // Reset values
    @(negedge clk_i);
    checkOutput("rstReqReady", {31'd0, req_ready_o}, 32'd1);
    checkOutput("rstRespValid", {31'd0, resp_valid_o}, 32'd0);
    checkOutput("rstStart", {31'd0, div_start_o}, 32'd0);
    checkOutput("rstData", resp_data_o, 32'd0);
    checkOutput("rstDividend", div_dividend_o, 32'd0);
    reset_i = 1'b0;
    @(negedge clk_i);

    // Signed divide then cached remainder
    divDelay = 2;
    applyStimulus(F3_DIV, 32'hFFFF_FF99, 32'h14, 5'd1, 0);
    applyStimulus(F3_REM, 32'hFFFF_FF99, 32'h14, 5'd2, 0);
    applyStimulus(F3_DIV, 32'hFFFF_FFF6, 32'hFFFF_FFFA, 5'd3, 0);
    applyStimulus(F3_REM, 32'hFFFF_FFF6, 32'hFFFF_FFFA, 5'd4, 0);
    applyStimulus(F3_DIV, 32'd5, 32'hFFFF_FFFD, 5'd5, 0);
    applyStimulus(F3_REM, 32'd5, 32'hFFFF_FFFD, 5'd6, 0);
    // Unsigned, cache hit, then signedness change forces a relaunch
    applyStimulus(F3_DIVU, 32'd10, 32'd3, 5'd7, 0);
    applyStimulus(F3_REMU, 32'd10, 32'd3, 5'd8, 0);
    applyStimulus(F3_DIV, 32'd10, 32'd3, 5'd9, 0);
    // Divide-by-zero, overflow and illegal funct3
    applyStimulus(F3_DIVU, 32'd7, 32'd0, 5'd10, 0);
    applyStimulus(F3_REMU, 32'd7, 32'd0, 5'd11, 0);
    applyStimulus(F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 0);
    applyStimulus(F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 0);
    applyStimulus(3'b001, 32'd9, 32'd4, 5'd14, 0);

    // Flush in IDLE: request not accepted
    startsBefore = startCount;
    @(negedge clk_i);
    req_valid_i  = 1'b1;
    flush_i      = 1'b1;
    req_funct3_i = F3_DIVU;
    req_rs1_i    = 32'd9;
    req_rs2_i    = 32'd0;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    flush_i     = 1'b0;
    checkOutput("flushIdleResp", {31'd0, resp_valid_o}, 32'd0);
    checkOutput("flushIdleReady", {31'd0, req_ready_o}, 32'd1);
    @(negedge clk_i);
    checkOutput("flushIdleStart", startCount - startsBefore, 0);

    // Flush in WAIT: drain until the divider finishes, no response
    divDelay     = 10;
    req_valid_i  = 1'b1;
    req_funct3_i = F3_DIV;
    req_rs1_i    = 32'd100;
    req_rs2_i    = 32'd7;
    req_tag_i    = 5'd15;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    @(negedge clk_i);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i  = 1'b0;
    drainBad = 1'b0;
    for (int k = 3; k <= 12; k++) begin
      if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b0) drainBad = 1'b1;
      @(negedge clk_i);
    end
    checkOutput("drainQuiet", {31'd0, drainBad}, 32'd0);
    checkOutput("drainExit", {31'd0, req_ready_o}, 32'd1);
    mCacheValid = 1'b0;
    divDelay    = 1;
    applyStimulus(F3_REM, 32'd100, 32'd7, 5'd16, 0);

    // Response back-pressure: outputs held stable
    applyStimulus(F3_DIVU, 32'd1000, 32'd33, 5'd17, 5);
    applyStimulus(F3_REMU, 32'd1000, 32'd33, 5'd18, 5);

    // Flush in RESP drops the response
    resp_ready_i = 1'b0;
    req_valid_i  = 1'b1;
    req_funct3_i = F3_DIVU;
    req_rs1_i    = 32'd7;
    req_rs2_i    = 32'd0;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    checkOutput("flushRespValid", {31'd0, resp_valid_o}, 32'd1);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    checkOutput("flushRespDrop", {31'd0, resp_valid_o}, 32'd0);
    checkOutput("flushRespReady", {31'd0, req_ready_o}, 32'd1);
    resp_ready_i = 1'b1;

    // Divider never answers: timeout error response
    divWithhold = 1'b1;
    applyStimulus(F3_DIV, 32'd55, 32'd5, 5'd19, 0);
    divWithhold = 1'b0;
    divDelay    = 0;
    applyStimulus(F3_REM, 32'd55, 32'd5, 5'd20, 0);

    // Reset mid-WAIT
    divDelay     = 20;
    req_valid_i  = 1'b1;
    req_funct3_i = F3_DIVU;
    req_rs1_i    = 32'd4321;
    req_rs2_i    = 32'd17;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    reset_i    = 1'b1;
    divPending = 1'b0;
    #1;
    checkOutput("midRstReady", {31'd0, req_ready_o}, 32'd1);
    checkOutput("midRstValid", {31'd0, resp_valid_o}, 32'd0);
    checkOutput("midRstDividend", div_dividend_o, 32'd0);
    checkOutput("midRstSigned", {31'd0, div_is_signed_o}, 32'd0);
    @(negedge clk_i);
    reset_i     = 1'b0;
    mCacheValid = 1'b0;
    divDelay    = 1;
    applyStimulus(F3_REMU, 32'd55, 32'd5, 5'd21, 0);

    // Randomised traffic with biased operands to reach every path
    lastA = 32'd55;
    lastB = 32'd5;
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 9);
      f3  = {1'b1, 2'($urandom)};
      a   = $urandom;
      b   = $urandom;
      case (sel)
        0: f3 = 3'($urandom_range(0, 3));
        1, 2: begin a = lastA; b = lastB; end
        3: b = 32'd0;
        4: begin a = INT_MIN; b = 32'hFFFF_FFFF; end
        5, 6: begin
          a = 32'($urandom_range(0, 400)) - 32'd200;
          b = 32'($urandom_range(0, 20)) - 32'd10;
        end
        default: ;
      endcase
      divDelay = $urandom_range(0, 4);
      applyStimulus(f3, a, b, 5'($urandom), (sel == 7) ? 2 : 0);
      lastA = a;
      lastB = b;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
